// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter onto the block RAM data port
//
// Shares the RAM data port between the core load/store path (port A) and the
// loader/debug master (port B). Each access is byte, half or word sized. The
// block maps it onto a word-indexed RAM access with per-byte lane enables and
// realigns the load data that comes back.
//
// Ports (x in {a, b}):
//   clk24, reset_n            clock, synchronous active-low reset
//   x_req/x_we/x_size         request, store flag, size (00 byte, 01 half, 10 word)
//   x_addr/x_wdata            byte address, right-justified store data
//   x_gnt                     access accepted this cycle (combinational)
//   x_rvalid/x_rdata          load result, one cycle after the grant
//   x_err                     one-cycle pulse after a rejected grant
//   mem_en/mem_waddr/mem_be   RAM strobe, word index, byte write lanes
//   mem_wdata/mem_rdata       RAM write data in lanes, RAM read data

module mem_port_arbiter #(
    parameter int MEMORY_SIZE = 4096,
    parameter int WORD_AW     = 12
) (
    input  logic               clk24,
    input  logic               reset_n,

    input  logic               a_req,
    input  logic               a_we,
    input  logic [1:0]         a_size,
    input  logic [31:0]        a_addr,
    input  logic [31:0]        a_wdata,
    output logic               a_gnt,
    output logic               a_rvalid,
    output logic [31:0]        a_rdata,
    output logic               a_err,

    input  logic               b_req,
    input  logic               b_we,
    input  logic [1:0]         b_size,
    input  logic [31:0]        b_addr,
    input  logic [31:0]        b_wdata,
    output logic               b_gnt,
    output logic               b_rvalid,
    output logic [31:0]        b_rdata,
    output logic               b_err,

    output logic               mem_en,
    output logic [WORD_AW-1:0] mem_waddr,
    output logic [3:0]         mem_be,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    localparam logic       PORT_A    = 1'b0;
    localparam logic       PORT_B    = 1'b1;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    // Most recently granted port; the other port wins a conflict.
    logic        last;

    // Pending load / error tracking for the cycle after a grant.
    logic        rv_a_q;
    logic        rv_b_q;
    logic        err_a_q;
    logic        err_b_q;
    logic [1:0]  rd_off_q;
    logic [1:0]  rd_size_q;

    // Fields of whichever port holds the grant this cycle.
    logic        gnt_a;
    logic        gnt_b;
    logic        any_gnt;
    logic        g_we;
    logic [1:0]  g_size;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [1:0]  off;
    logic [31:0] word_idx;
    logic        size_bad;
    logic        misaligned;
    logic        out_of_range;
    logic        reject;
    logic        accept;
    logic [31:0] shifted;
    logic [31:0] aligned;

    // Arbitration and access checking.
    always_comb begin
        gnt_a   = reset_n && a_req && (!b_req || (last == PORT_B));
        gnt_b   = reset_n && b_req && !gnt_a;
        any_gnt = gnt_a || gnt_b;

        g_we    = gnt_b ? b_we    : a_we;
        g_size  = gnt_b ? b_size  : a_size;
        g_addr  = gnt_b ? b_addr  : a_addr;
        g_wdata = gnt_b ? b_wdata : a_wdata;
        off     = g_addr[1:0];

        size_bad   = (g_size == SIZE_BAD);
        misaligned = ((g_size == SIZE_HALF) && off[0]) ||
                     ((g_size == SIZE_WORD) && (off != 2'b00));
        // A word index at or beyond the RAM depth means high address bits are set.
        word_idx     = {2'b00, g_addr[31:2]};
        out_of_range = (word_idx >= 32'(MEMORY_SIZE));

        // Every rejection reason produces the same response, so the
        // checks need no ordering here.
        reject = size_bad || misaligned || out_of_range;
        accept = any_gnt && !reject;
    end

    assign a_gnt = gnt_a;
    assign b_gnt = gnt_b;

    // RAM command.
    always_comb begin
        mem_en    = accept;
        mem_waddr = g_addr[WORD_AW+1:2];
        mem_wdata = g_wdata << {off, 3'b000};
        mem_be    = 4'b0000;
        if (accept && g_we) begin
            case (g_size)
                SIZE_BYTE: mem_be = 4'b0001 << off;
                SIZE_HALF: mem_be = 4'b0011 << off;
                default:   mem_be = 4'b1111;
            endcase
        end
    end

    // Round-robin pointer and next-cycle response bookkeeping.
    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            last      <= PORT_B;
            rv_a_q    <= 1'b0;
            rv_b_q    <= 1'b0;
            err_a_q   <= 1'b0;
            err_b_q   <= 1'b0;
            rd_off_q  <= 2'b00;
            rd_size_q <= SIZE_BYTE;
        end else begin
            if (any_gnt) begin
                last <= gnt_b ? PORT_B : PORT_A;
            end
            rv_a_q  <= gnt_a && accept && !g_we;
            rv_b_q  <= gnt_b && accept && !g_we;
            err_a_q <= gnt_a && reject;
            err_b_q <= gnt_b && reject;
            if (accept && !g_we) begin
                rd_off_q  <= off;
                rd_size_q <= g_size;
            end
        end
    end

    // Load data realignment. Responses are gated by reset_n so a reset
    // in the cycle after a grant drops the pending rvalid/err immediately.
    always_comb begin
        shifted = mem_rdata >> {rd_off_q, 3'b000};
        case (rd_size_q)
            SIZE_BYTE: aligned = {24'h000000, shifted[7:0]};
            SIZE_HALF: aligned = {16'h0000, shifted[15:0]};
            default:   aligned = shifted;
        endcase

        a_rvalid = reset_n && rv_a_q;
        b_rvalid = reset_n && rv_b_q;
        a_err    = reset_n && err_a_q;
        b_err    = reset_n && err_b_q;
        a_rdata  = a_rvalid ? aligned : 32'h0000_0000;
        b_rdata  = b_rvalid ? aligned : 32'h0000_0000;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    logic        clk24;
    logic        reset_n;
    logic        a_req, a_we, b_req, b_we;
    logic [1:0]  a_size, b_size;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_en;
    logic [11:0] mem_waddr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.MEMORY_SIZE(4096), .WORD_AW(12)) dut (
        .clk24(clk24), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_en(mem_en), .mem_waddr(mem_waddr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk24 = 1'b0;
        forever #5 clk24 = ~clk24;
    end

    // Write-first synchronous RAM model.
    logic [31:0] ram [0:4095];
    logic [31:0] ram_w;
    always @(posedge clk24) begin
        if (mem_en) begin
            ram_w = ram[mem_waddr];
            for (int k = 0; k < 4; k++)
                if (mem_be[k]) ram_w[8*k +: 8] = mem_wdata[8*k +: 8];
            ram[mem_waddr] <= ram_w;
            mem_rdata      <= ram_w;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drv_a(input logic req, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        a_req = req; a_we = we; a_size = size; a_addr = addr; a_wdata = wdata;
    endtask

    task automatic drv_b(input logic req, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        b_req = req; b_we = we; b_size = size; b_addr = addr; b_wdata = wdata;
    endtask

    task automatic idle();
        drv_a(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drv_b(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drv_a(1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
        drv_b(1'b1, 1'b0, 2'b10, 32'h4, 32'h0);
        repeat (3) @(negedge clk24);
        #1;
        n_tests++;
        if ({a_gnt, b_gnt, mem_en} !== 3'b000) begin
            n_fail++; $display("FAIL reset_gnt: got %b expected 000", {a_gnt, b_gnt, mem_en});
        end
        n_tests++;
        if ({a_rvalid, b_rvalid, a_err, b_err} !== 4'b0000 || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %b/%h/%h expected 0000/0/0",
                               {a_rvalid, b_rvalid, a_err, b_err}, a_rdata, b_rdata);
        end
        reset_n = 1'b1;
        #1;
        n_tests++;
        if ({a_gnt, b_gnt, mem_en} !== 3'b101) begin
            n_fail++; $display("FAIL reset_first_a: got %b expected 101", {a_gnt, b_gnt, mem_en});
        end
        @(negedge clk24);
        #1;
        n_tests++;
        if ({a_gnt, b_gnt, a_rvalid} !== 3'b011) begin
            n_fail++; $display("FAIL reset_then_b: got %b expected 011", {a_gnt, b_gnt, a_rvalid});
        end
        idle();
        @(negedge clk24);
    endtask

    task automatic test_byte();
        drv_a(1'b1, 1'b1, 2'b00, 32'h0000_0103, 32'h0000_00AB);
        #1;
        n_tests++;
        if (a_gnt !== 1'b1 || mem_en !== 1'b1 || mem_be !== 4'b1000 ||
            mem_wdata[31:24] !== 8'hAB || mem_waddr !== 12'h040) begin
            n_fail++; $display("FAIL byte_store: got gnt=%b en=%b be=%b wd=%h wa=%h expected 1 1 1000 AB.. 040",
                               a_gnt, mem_en, mem_be, mem_wdata, mem_waddr);
        end
        @(negedge clk24);
        drv_a(1'b1, 1'b0, 2'b00, 32'h0000_0103, 32'h0);
        #1;
        n_tests++;
        if (a_gnt !== 1'b1 || mem_en !== 1'b1 || mem_be !== 4'b0000) begin
            n_fail++; $display("FAIL byte_load_cmd: got gnt=%b en=%b be=%b expected 1 1 0000",
                               a_gnt, mem_en, mem_be);
        end
        @(negedge clk24);
        idle();
        #1;
        n_tests++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h0000_00AB || b_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL byte_load_data: got rv=%b rd=%h expected 1 000000ab", a_rvalid, a_rdata);
        end
        @(negedge clk24);
        #1;
        n_tests++;
        if (a_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL byte_rvalid_pulse: got %b expected 0", a_rvalid);
        end
    endtask

    task automatic test_half_word();
        drv_b(1'b1, 1'b1, 2'b10, 32'h0000_0200, 32'h1234_5678);
        #1;
        n_tests++;
        if (b_gnt !== 1'b1 || mem_be !== 4'b1111 || mem_waddr !== 12'h080 || mem_wdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL word_store: got gnt=%b be=%b wa=%h wd=%h expected 1 1111 080 12345678",
                               b_gnt, mem_be, mem_waddr, mem_wdata);
        end
        @(negedge clk24);
        drv_b(1'b1, 1'b0, 2'b01, 32'h0000_0202, 32'h0);
        @(negedge clk24);
        drv_b(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drv_a(1'b1, 1'b0, 2'b00, 32'h0000_0201, 32'h0);
        #1;
        n_tests++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h0000_1234 || a_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL half_load: got rv=%b rd=%h expected 1 00001234", b_rvalid, b_rdata);
        end
        @(negedge clk24);
        drv_a(1'b1, 1'b0, 2'b01, 32'h0000_0200, 32'h0);
        #1;
        n_tests++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h0000_0056) begin
            n_fail++; $display("FAIL byte1_load: got rv=%b rd=%h expected 1 00000056", a_rvalid, a_rdata);
        end
        @(negedge clk24);
        drv_a(1'b1, 1'b1, 2'b01, 32'h0000_0202, 32'h0000_BEEF);
        #1;
        n_tests++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h0000_5678) begin
            n_fail++; $display("FAIL half0_load: got rv=%b rd=%h expected 1 00005678", a_rvalid, a_rdata);
        end
        n_tests++;
        if (mem_be !== 4'b1100 || mem_wdata[31:16] !== 16'hBEEF) begin
            n_fail++; $display("FAIL half_store_lanes: got be=%b wd=%h expected 1100 beef....", mem_be, mem_wdata);
        end
        @(negedge clk24);
        drv_a(1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'h0);
        @(negedge clk24);
        idle();
        #1;
        n_tests++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'hBEEF_5678) begin
            n_fail++; $display("FAIL word_after_half: got rv=%b rd=%h expected 1 beef5678", a_rvalid, a_rdata);
        end
        @(negedge clk24);
    endtask

    task automatic test_contention();
        logic [3:0]  ka, kb;
        logic        exp_a_prev;
        logic [31:0] exp_d_prev;
        // Preload A words at 0x400.. and B words at 0x800.. through port A.
        for (int k = 0; k < 4; k++) begin
            drv_a(1'b1, 1'b1, 2'b10, 32'h400 + 32'(4*k), 32'hA000_0000 + 32'(k));
            @(negedge clk24);
            drv_a(1'b1, 1'b1, 2'b10, 32'h800 + 32'(4*k), 32'hB000_0000 + 32'(k));
            @(negedge clk24);
        end
        idle();
        // Lone B grant leaves last = B so A wins the first conflict.
        drv_b(1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
        @(negedge clk24);
        ka = 0; kb = 0; exp_a_prev = 1'b0; exp_d_prev = 32'h0;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                drv_a(1'b1, 1'b0, 2'b10, 32'h400 + 32'(4*ka), 32'h0);
                drv_b(1'b1, 1'b0, 2'b10, 32'h800 + 32'(4*kb), 32'h0);
            end else begin
                idle();
            end
            #1;
            if (i > 0) begin
                n_tests++;
                if (exp_a_prev ? (a_rvalid !== 1'b1 || b_rvalid !== 1'b0 || a_rdata !== exp_d_prev)
                               : (b_rvalid !== 1'b1 || a_rvalid !== 1'b0 || b_rdata !== exp_d_prev)) begin
                    n_fail++; $display("FAIL contention_rdata[%0d]: got rv=%b%b a=%h b=%h expected port_a=%b data %h",
                                       i, a_rvalid, b_rvalid, a_rdata, b_rdata, exp_a_prev, exp_d_prev);
                end
            end
            if (i < 8) begin
                n_tests++;
                if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL contention_gnt[%0d]: got %b%b expected %b",
                                       i, a_gnt, b_gnt, (i % 2 == 0) ? 2'b10 : 2'b01);
                end
                exp_a_prev = (i % 2 == 0);
                if (exp_a_prev) begin
                    exp_d_prev = 32'hA000_0000 + 32'(ka); ka++;
                end else begin
                    exp_d_prev = 32'hB000_0000 + 32'(kb); kb++;
                end
            end
            @(negedge clk24);
        end
    endtask

    task automatic test_errors();
        // Known value at word 0, where a masked 0x4000 store would land.
        drv_a(1'b1, 1'b1, 2'b10, 32'h0, 32'h55AA_55AA);
        @(negedge clk24);
        drv_a(1'b1, 1'b0, 2'b01, 32'h0000_0001, 32'h0);
        #1;
        n_tests++;
        if (a_gnt !== 1'b1 || mem_en !== 1'b0) begin
            n_fail++; $display("FAIL err_misalign_cmd: got gnt=%b en=%b expected 1 0", a_gnt, mem_en);
        end
        @(negedge clk24);
        drv_a(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drv_b(1'b1, 1'b1, 2'b10, 32'h0000_4000, 32'hDEAD_BEEF);
        #1;
        n_tests++;
        if (a_err !== 1'b1 || a_rvalid !== 1'b0 || b_gnt !== 1'b1 || mem_en !== 1'b0) begin
            n_fail++; $display("FAIL err_misalign_resp: got err=%b rv=%b bgnt=%b en=%b expected 1 0 1 0",
                               a_err, a_rvalid, b_gnt, mem_en);
        end
        @(negedge clk24);
        drv_b(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drv_a(1'b1, 1'b1, 2'b11, 32'h0000_0200, 32'hFFFF_FFFF);
        #1;
        n_tests++;
        if (b_err !== 1'b1 || a_err !== 1'b0 || a_gnt !== 1'b1 || mem_en !== 1'b0) begin
            n_fail++; $display("FAIL err_range_resp: got berr=%b aerr=%b agnt=%b en=%b expected 1 0 1 0",
                               b_err, a_err, a_gnt, mem_en);
        end
        @(negedge clk24);
        drv_a(1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
        #1;
        n_tests++;
        if (a_err !== 1'b1 || b_err !== 1'b0) begin
            n_fail++; $display("FAIL err_size_resp: got aerr=%b berr=%b expected 1 0", a_err, b_err);
        end
        @(negedge clk24);
        drv_a(1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'h0);
        #1;
        n_tests++;
        if (a_err !== 1'b0 || a_rdata !== 32'h55AA_55AA) begin
            n_fail++; $display("FAIL err_word0_intact: got err=%b rd=%h expected 0 55aa55aa", a_err, a_rdata);
        end
        @(negedge clk24);
        idle();
        #1;
        n_tests++;
        if (a_rdata !== 32'hBEEF_5678) begin
            n_fail++; $display("FAIL err_word200_intact: got %h expected beef5678", a_rdata);
        end
        @(negedge clk24);
    endtask

    task automatic test_reset_mid_load();
        drv_a(1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'h0);
        #1;
        n_tests++;
        if (a_gnt !== 1'b1) begin
            n_fail++; $display("FAIL midreset_gnt: got %b expected 1", a_gnt);
        end
        @(negedge clk24);
        idle();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin
            n_fail++; $display("FAIL midreset_drop: got rv=%b rd=%h expected 0 0", a_rvalid, a_rdata);
        end
        @(negedge clk24);
        reset_n = 1'b1;
        #1;
        n_tests++;
        if (a_rvalid !== 1'b0 || a_err !== 1'b0) begin
            n_fail++; $display("FAIL midreset_after: got rv=%b err=%b expected 0 0", a_rvalid, a_err);
        end
        @(negedge clk24);
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        test_reset();
        test_byte();
        test_half_word();
        test_contention();
        test_errors();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
